alu_issue_arbiter: RTL and testbench

Shares one combinational `ALU` instance between `NREQ` independent requesters, such as the integer issue slot and the address-generation path.
- Round-robin arbitration.
- Valid/ready handshake per requester.
- Single-entry registered result stage with backpressure.
- Sits between the requesters and the writeback/consumer logic, and returns each result tagged with the winning requester's index.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/ALU.sv | 30 +++
 rtl/alu_issue_arbiter.sv | 113 +++++++++++
 tb/tb_alu_issue_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue arbiter: opcodes, widths and
// the result-stage state encoding.
package alu_pkg;

   localparam int ALU_W = 32;
   localparam int OP_W  = 3;
   localparam int ID_W  = 2;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_SLTU = 3'b010,
      ALU_SLT  = 3'b011,
      ALU_SLL  = 3'b100,
      ALU_SRL  = 3'b101,
      ALU_OR   = 3'b110,
      ALU_AND  = 3'b111
   } alu_op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_e;

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit integer ALU shared by all issue paths.
module ALU
   import alu_pkg::*;
(
   input  logic [OP_W-1:0]  op,
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   output logic [ALU_W-1:0] result
);

   // Shift amounts of 32 or more flush the operand rather than wrapping.
   logic big_shift;
   assign big_shift = |b[ALU_W-1:5];

   always_comb begin
      result = '0;
      case (alu_op_e'(op))
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLTU: result = {{(ALU_W-1){1'b0}}, (a < b)};
         ALU_SLT:  result = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL:  result = big_shift ? '0 : (a << b[4:0]);
         ALU_SRL:  result = big_shift ? '0 : (a >> b[4:0]);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a
// single-entry registered result stage that honours consumer backpressure.
module alu_issue_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*3-1:0] req_op,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              resp_valid,
   output logic [W-1:0]      resp_result,
   output logic [1:0]        resp_id,
   input  logic              resp_ready,
   output logic [15:0]       ops_done
);

   stage_e          state_q;
   stage_e          state_d;
   logic [ID_W-1:0] rr_ptr;
   logic            slot_free;
   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic            accept;
   int              cand;
   logic [OP_W-1:0] sel_op;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic [W-1:0]    alu_out;

   assign resp_valid = (state_q == ST_FULL);
   assign slot_free  = !resp_valid || resp_ready;
   assign accept     = grant_found;

   // Rotating priority scan from rr_ptr; gated by rst_n so nothing is offered in reset.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      req_ready   = '0;
      cand        = 0;
      if (slot_free && rst_n) begin
         for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            for (int i = 0; i < NREQ; i++) begin
               if (!grant_found && (i == cand) && req_valid[i]) begin
                  grant_found = 1'b1;
                  grant_idx   = ID_W'(i);
               end
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_found && (grant_idx == ID_W'(i));
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_op = req_op[OP_W*i +: OP_W];
            sel_a  = req_a[W*i +: W];
            sel_b  = req_b[W*i +: W];
         end
      end
   end

   ALU u_alu (
      .op     (sel_op),
      .a      (sel_a),
      .b      (sel_b),
      .result (alu_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (!accept && resp_ready) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Result, owner tag and pointer only move on accept; a drain leaves them intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_result <= '0;
         resp_id     <= '0;
         rr_ptr      <= '0;
         ops_done    <= '0;
      end else if (accept) begin
         resp_result <= alu_out;
         resp_id     <= grant_idx;
         rr_ptr      <= (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
         ops_done    <= ops_done + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed self-checking bench for alu_issue_arbiter with two requesters.
module tb_alu_issue_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [5:0]  req_op;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  req_ready;
   logic        resp_valid;
   logic [31:0] resp_result;
   logic [1:0]  resp_id;
   logic        resp_ready;
   logic [15:0] ops_done;

   int checkCount = 0;
   int failCount  = 0;

   alu_issue_arbiter #(.NREQ(2), .W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_result (resp_result),
      .resp_id     (resp_id),
      .resp_ready  (resp_ready),
      .ops_done    (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [1:0] valid,
                                input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic rrdy);
      req_valid  = valid;
      req_op     = {op1, op0};
      req_a      = {a1, a0};
      req_b      = {b1, b0};
      resp_ready = rrdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(2'b11, 3'd0, 32'd1, 32'd1, 3'd0, 32'd2, 32'd2, 1'b1);
      #2;
      checkOutput("reset_ready", {30'd0, req_ready}, 32'd0);
      checkOutput("reset_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("reset_result", resp_result, 32'd0);
      checkOutput("reset_id", {30'd0, resp_id}, 32'd0);
      checkOutput("reset_ops", {16'd0, ops_done}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Single request on requester 0: 5 + 7
      applyStimulus(2'b01, 3'b000, 32'd5, 32'd7, 3'd0, 32'd0, 32'd0, 1'b1);
      checkOutput("single_ready", {30'd0, req_ready}, 32'd1);
      nextEdge();
      applyStimulus(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);
      checkOutput("single_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("single_result", resp_result, 32'd12);
      checkOutput("single_id", {30'd0, resp_id}, 32'd0);
      checkOutput("single_ops", {16'd0, ops_done}, 32'd1);
      nextEdge();
      checkOutput("drain_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("drain_hold", resp_result, 32'd12);

      // Back-to-back ops on requester 1 alone
      applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b1);
      checkOutput("sltu_ready", {30'd0, req_ready}, 32'd2);
      nextEdge();
      checkOutput("sltu_result", resp_result, 32'd0);
      checkOutput("sltu_id", {30'd0, resp_id}, 32'd1);
      applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'b011, 32'hFFFF_FFFF, 32'd1, 1'b1);
      checkOutput("slt_ready", {30'd0, req_ready}, 32'd2);
      nextEdge();
      checkOutput("slt_result", resp_result, 32'd1);
      applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'b100, 32'd1, 32'd31, 1'b1);
      nextEdge();
      checkOutput("sll31_result", resp_result, 32'h8000_0000);
      applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'b100, 32'd1, 32'd32, 1'b1);
      nextEdge();
      checkOutput("sll32_result", resp_result, 32'd0);
      applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'b101, 32'h8000_0000, 32'd4, 1'b1);
      nextEdge();
      checkOutput("srl4_result", resp_result, 32'h0800_0000);
      checkOutput("srl4_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("burst_ops", {16'd0, ops_done}, 32'd6);

      // Contention: pointer is back at 0, expect 0,1,0,1
      applyStimulus(2'b11, 3'b000, 32'd10, 32'd1, 3'b110, 32'hF0, 32'h0F, 1'b1);
      checkOutput("fair0_ready", {30'd0, req_ready}, 32'd1);
      nextEdge();
      checkOutput("fair0_id", {30'd0, resp_id}, 32'd0);
      checkOutput("fair0_result", resp_result, 32'd11);
      checkOutput("fair1_ready", {30'd0, req_ready}, 32'd2);
      nextEdge();
      checkOutput("fair1_id", {30'd0, resp_id}, 32'd1);
      checkOutput("fair1_result", resp_result, 32'hFF);
      checkOutput("fair2_ready", {30'd0, req_ready}, 32'd1);
      nextEdge();
      checkOutput("fair2_id", {30'd0, resp_id}, 32'd0);
      nextEdge();
      checkOutput("fair3_id", {30'd0, resp_id}, 32'd1);
      checkOutput("fair_ops", {16'd0, ops_done}, 32'd10);
      applyStimulus(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b1);
      nextEdge();
      checkOutput("fair_drain", {31'd0, resp_valid}, 32'd0);

      // Backpressure: 3 - 5 held while the consumer stalls
      applyStimulus(2'b01, 3'b001, 32'd3, 32'd5, 3'd0, 32'd0, 32'd0, 1'b0);
      checkOutput("bp_first_ready", {30'd0, req_ready}, 32'd1);
      nextEdge();
      applyStimulus(2'b10, 3'd0, 32'd0, 32'd0, 3'b000, 32'd100, 32'd23, 1'b0);
      for (int c = 0; c < 4; c++) begin
         checkOutput("bp_ready", {30'd0, req_ready}, 32'd0);
         checkOutput("bp_valid", {31'd0, resp_valid}, 32'd1);
         checkOutput("bp_result", resp_result, 32'hFFFF_FFFE);
         checkOutput("bp_id", {30'd0, resp_id}, 32'd0);
         nextEdge();
      end
      resp_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", {30'd0, req_ready}, 32'd2);
      nextEdge();
      checkOutput("bp_next_result", resp_result, 32'd123);
      checkOutput("bp_next_id", {30'd0, resp_id}, 32'd1);
      checkOutput("bp_ops", {16'd0, ops_done}, 32'd12);

      // Async reset while FULL, between clock edges
      applyStimulus(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b0);
      checkOutput("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("arst_result", resp_result, 32'd0);
      checkOutput("arst_ops", {16'd0, ops_done}, 32'd0);
      applyStimulus(2'b11, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b000, 32'd1, 32'd1, 1'b1);
      checkOutput("arst_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_ready", {30'd0, req_ready}, 32'd1);
      nextEdge();
      checkOutput("post_rst_id", {30'd0, resp_id}, 32'd0);
      checkOutput("post_rst_result", resp_result, 32'h0F00_0F00);
      checkOutput("post_rst_ops", {16'd0, ops_done}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
